aes128_round_sequencer: RTL
===========================

# aes128_round_sequencer

Iterative AES-128 encryption controller. Accepts one plaintext/key pair and drives the shared round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey chain) through the initial AddRoundKey, nine full rounds and the final round. It expands the round keys on the fly and returns the ciphertext over a valid/ready handshake. It sits between the host-side block interface and the round datapath and owns all round sequencing and round-key generation.

## Interface
- NR, 10, number of rounds. Only 10 is legal for the AES-128 product build; values 1..10 are allowed for reduced-round testing only.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  block can accept input. High only in IDLE.
- in_text  in  128  plaintext; [127:120] is byte 0 (FIPS-197 order).
- in_key  in  128  cipher key; w0=[127:96] .. w3=[31:0].
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_text  out  128  ciphertext, same byte order as in_text.
- rnd_valid  out  1  one-cycle strobe issuing a round to the datapath.
- rnd_mode  out  2  operation: 0 = AddRoundKey only, 1 = full round, 2 = final round (no MixColumns), 3 = unused.
- rnd_round  out  4  round index 0..NR being issued.
- rnd_state  out  128  state operand for the round.
- rnd_key  out  128  round key for the round.
- rnd_done  in  1  datapath result valid. Latency ≥1 cycle after rnd_valid.
- rnd_result  in  128  datapath output state.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&in_ready: state_reg<=in_text, key_reg<=in_key, round<=0, go to ISSUE.
- **ISSUE** (exactly one cycle)
  - rnd_valid=1, rnd_state=state_reg, rnd_key=key_reg, rnd_round=round.
  - rnd_mode = 0 if round==0, 2 if round==NR, else 1.
  - At the same edge: key_reg <= KeyExp(key_reg, rcon[round+1]) when round<NR. Go to WAIT.
- **WAIT**
  - Holds until rnd_done.
  - On rnd_done: state_reg<=rnd_result. If round==NR, go to DONE; else round<=round+1 and go to ISSUE.
- **DONE**
  - out_valid=1, out_text=state_reg, held stable until out_ready.
  - On out_valid&out_ready: go to IDLE.
- **KeyExp**
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - SubWord uses four instances of the team's S-box.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- rnd_done is sampled only in WAIT. It is ignored in IDLE/ISSUE/DONE and must not alter state_reg or round.
- rnd_result is captured only on the rnd_done cycle in WAIT.
- in_valid is ignored while busy. Input is not buffered and no second job is queued.
- rnd_state, rnd_key and rnd_round are meaningful only when rnd_valid=1. They are driven from registers, with no combinational path from inputs.

## Timing
- Reset (synchronous, takes effect at the edge where reset=1):
  - FSM goes to IDLE; round=0; state_reg and key_reg are cleared to 0.
  - in_ready=1 the cycle after reset.
  - out_valid=0, rnd_valid=0, busy=0, out_text=0, rnd_mode=0, rnd_round=0.
- Reset mid-job (any state): the job is abandoned and no out_valid is produced. A late rnd_done after reset is ignored because the FSM is in IDLE.
- Throughput per round: 1 ISSUE cycle + L WAIT cycles, where L is the datapath latency (≥1).
- With L=1 and accept on cycle T:
  - ISSUE r0 at T+1; ISSUE rk at T+1+2k.
  - ISSUE r10 at T+21, WAIT at T+22, out_valid at T+23.
  - Total: 2·(NR+1)+1 cycles from accept to out_valid.
- out_valid back-pressure: if out_ready=0, DONE persists indefinitely with out_text stable.
- in_ready rises the cycle after the out handshake.
- No zero-latency path: in_valid→out_valid and rnd_done→rnd_valid each take at least one register stage.

## Test plan
- **FIPS-197 App. B.** Bench uses a 1-cycle behavioural round model. Drive in_text=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c.
  - Round-0 result = 193de3bea0f4e22b9ac68d2ae9f84808.
  - rnd_key at round 1 = a0fafe1788542cb123a339392a6c7605; at round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - out_text = 3925841d02dc09fbdc118597196a0b32; out_valid at accept+23.
- **FIPS-197 App. C.1.** in_text=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f → out_text=69c4e0d86a7b0430d8cdb78070b4c55a.
  - rnd_mode sequence: 0, then 1×9, then 2.
- **Variable latency.** Round-model latency randomized 1..5 per round → ciphertext still 69c4e0d8...; exactly 11 rnd_valid pulses.
- **Back-pressure and ignored inputs.**
  - Hold out_ready=0 for 10 cycles → out_text stable, in_ready=0 throughout.
  - in_valid pulses during busy are dropped; the next accept happens only after the handshake.
- **Reset mid-job.** Assert reset in WAIT of round 5, then inject a stray rnd_done → no out_valid, in_ready=1, round=0. A following App. B job produces 3925841d....
- **Spurious rnd_done.** Pulse rnd_done in IDLE and during ISSUE → no state change; the App. C.1 result is unaffected.

Source files
------------

// File: rtl/aes128_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes128_round_sequencer
//
// Iterative AES-128 encryption controller. It takes one plaintext/key pair,
// issues the initial AddRoundKey, NR-1 full rounds and the final round to an
// external shared round datapath, and expands the round keys on the fly. The
// ciphertext is returned over a valid/ready handshake.
//
// Ports
//   clk        in   1    system clock, rising edge
//   reset      in   1    synchronous, active-high reset
//   in_valid   in   1    plaintext/key offered
//   in_ready   out  1    block can accept input (IDLE only)
//   in_text    in   128  plaintext, [127:120] is byte 0
//   in_key     in   128  cipher key, w0 = [127:96] .. w3 = [31:0]
//   out_valid  out  1    ciphertext available
//   out_ready  in   1    consumer accepts ciphertext
//   out_text   out  128  ciphertext, same byte order as in_text
//   rnd_valid  out  1    one-cycle strobe issuing a round
//   rnd_mode   out  2    0 = AddRoundKey only, 1 = full round, 2 = final round
//   rnd_round  out  4    round index 0..NR being issued
//   rnd_state  out  128  state operand for the round
//   rnd_key    out  128  round key for the round
//   rnd_done   in   1    datapath result valid (latency >= 1 cycle)
//   rnd_result in   128  datapath output state
//   busy       out  1    high in every state except IDLE
//   dbg_state  out  2    FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; ready may be high without valid. On this block in_ready is high only
// in IDLE and out_valid/out_text are held in DONE until out_ready is seen.
//
// NR must be 10 for the AES-128 product build; 1..10 is accepted only for
// reduced-round testing.
// ---------------------------------------------------------------------------

// Byte substitution table lookup (FIPS-197 S-box).
module aes128_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Entry i lives at bits [2047-8i -: 8]; 2047-8i == {~i, 3'b111}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[{~a, 3'b111} -: 8];
endmodule

module aes128_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         rnd_valid,
  output logic [1:0]   rnd_mode,
  output logic [3:0]   rnd_round,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  input  logic         rnd_done,
  input  logic [127:0] rnd_result,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] key_next;
  logic [3:0]   round;
  logic         last_round;

  // Key schedule signals
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_rot;
  logic [31:0] t_word;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;

  assign last_round = (round == LAST_ROUND);

  // -------------------------------------------------------------------------
  // On-the-fly key expansion. key_reg always holds the key of the round about
  // to be issued; during ISSUE it is advanced to the next round's key using
  // rcon[round+1].
  // -------------------------------------------------------------------------
  assign {w0, w1, w2, w3} = key_reg;

  // SubWord(RotWord(w3)): RotWord moves the top byte of w3 to the bottom.
  aes128_sbox u_sbox0 (.a(w3[23:16]), .y(sub_rot[31:24]));
  aes128_sbox u_sbox1 (.a(w3[15:8]),  .y(sub_rot[23:16]));
  aes128_sbox u_sbox2 (.a(w3[7:0]),   .y(sub_rot[15:8]));
  aes128_sbox u_sbox3 (.a(w3[31:24]), .y(sub_rot[7:0]));

  // rcon indexed by the round being issued, i.e. rcon[round+1].
  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_word   = sub_rot ^ {rcon, 24'h000000};
  assign n0       = w0 ^ t_word;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign key_next = {n0, n1, n2, n3};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. rnd_done only matters in WAIT.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (rnd_done)  state_nxt = last_round ? S_DONE : S_ISSUE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Working registers: block state, current round key and round counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= '0;
      key_reg   <= '0;
      round     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state_reg <= in_text;
            key_reg   <= in_key;
            round     <= '0;
          end
        end
        S_ISSUE: begin
          // The key for the round just issued has been handed out; advance it.
          if (!last_round) key_reg <= key_next;
        end
        S_WAIT: begin
          if (rnd_done) begin
            state_reg <= rnd_result;
            if (!last_round) round <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Operand buses come straight from registers.
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    rnd_valid = 1'b0;
    out_valid = 1'b0;
    out_text  = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_ISSUE: rnd_valid = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        out_text  = state_reg;
      end
      default: ;
    endcase

    if (round == 4'd0)    rnd_mode = 2'd0;
    else if (last_round)  rnd_mode = 2'd2;
    else                  rnd_mode = 2'd1;

    rnd_round = round;
    rnd_state = state_reg;
    rnd_key   = key_reg;
    dbg_state = state;
  end

endmodule
